bird_collide_judge: RTL and testbench
=====================================

Name: bird_collide_judge

Overview:
- Consumer side of the pipe generator interface: takes pipe positions, gap centres and score pulses, plus the bird's Y position.
- Owns the game state machine and drives `game_active` back to the pipe generator and bird physics.
- Detects bird/pipe, ground and ceiling collisions once per frame.
- Keeps a 3-digit BCD score and a BCD high score for the display/HUD logic.

Parameters:
- BIRD_X, 300, bird left-edge X (fixed)
- BIRD_SIZE, 32, bird sprite width and height in pixels
- PIPE_W, 80, pipe width in pixels
- PIPE_GAP_H, 220, gap height; half-gap = PIPE_GAP_H/2 = 110
- GROUND_Y, 700, ground line Y; bird bottom >= GROUND_Y is a hit
- DEATH_FRAMES, 60, frames spent in DEAD before OVER

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_en  in  1  one-cycle frame strobe
- start_btn  in  1  debounced, synchronous start/flap key; rising edge is used
- bird_y  in  12  bird top-edge Y
- pipe1_x  in  12  pipe 1 left edge
- pipe1_gap_y  in  12  pipe 1 gap centre
- pipe2_x  in  12  pipe 2 left edge
- pipe2_gap_y  in  12  pipe 2 gap centre
- score_pulse  in  1  one-cycle pass pulse from the pipe generator
- game_active  out  1  high only in PLAY
- game_over  out  1  high in OVER
- state  out  2  IDLE=0, PLAY=1, DEAD=2, OVER=3
- score_bcd  out  12  current score, 3 BCD digits
- high_bcd  out  12  best score, 3 BCD digits

Behaviour:
- Reset: async on `rst` high.
  - state=IDLE, game_active=0, game_over=0, score_bcd=0, high_bcd=0.
  - death counter=0, start edge flop=0.
- Start edge: `start_re` = start_btn & ~start_q, where start_q is start_btn registered every clk.
- Pipe hit per pipe n, all compares unsigned 13-bit to avoid wrap:
  - Horizontal overlap: pipe_x < BIRD_X+BIRD_SIZE and pipe_x+PIPE_W > BIRD_X.
  - Vertical miss: bird_y < gap_y-110 or bird_y+BIRD_SIZE > gap_y+110.
  - gap_y < 110 clamps the upper bound to 0.
  - Hit = horizontal overlap & vertical miss.
- Ground hit: bird_y+BIRD_SIZE >= GROUND_Y.
- Ceiling hit: bird_y == 0 or bird_y[11]==1 (negative wrap).
- `hit` = pipe1_hit | pipe2_hit | ground | ceiling. Combinational; sampled only on frame_en.
- FSM, registered, one transition per clk:
  - IDLE: start_re -> PLAY; score_bcd cleared to 0 in the same cycle.
  - PLAY: frame_en & hit -> DEAD; death counter loads 0. game_active drops the cycle after the sampling edge (1-cycle latency).
  - DEAD: each frame_en increments the counter. When the counter reaches DEATH_FRAMES-1 with frame_en -> OVER. On entering OVER, if score_bcd > high_bcd, high_bcd <= score_bcd. BCD compare equals numeric compare.
  - OVER: start_re -> PLAY, score cleared. start_re in DEAD is ignored.
- Score:
  - Increments on score_pulse only while state==PLAY. BCD ripple carry: 009->010, 099->100.
  - Saturates at 999.
  - Pulses in IDLE/DEAD/OVER are ignored.
  - score_pulse and a hit-sampling frame_en in the same cycle: the score still increments.
- Outputs are registered and decoded from the state register.
- Reset asserted mid-game returns everything to reset values immediately, including high_bcd.

Optional Feature:
- Macro: BIRD_PIPE_INVINCIBLE_EN.
- Defined: pipe1_hit and pipe2_hit are forced to 0; only ground and ceiling hits end the game. Used for bring-up/demo.
- Undefined: all four hit sources are active as specified above.

Test Plan:
- Reset, then one start_btn rising edge -> state=1, game_active=1 the next cycle, score_bcd=000.
- PLAY; pipe1_x=250, pipe1_gap_y=384, bird_y=370 (inside gap); frame_en -> stays PLAY. Same but bird_y=200 -> state=2 the cycle after frame_en. With BIRD_PIPE_INVINCIBLE_EN defined -> stays PLAY.
- PLAY; 10 score_pulses -> score_bcd=0x010. Preload 999 via 999 pulses, then 1 more -> stays 0x999.
- PLAY; bird_y=680 (bottom 712 >= 700) with pipes off-screen (x=1024); frame_en -> DEAD. After 60 frame_en -> OVER, game_over=1, high_bcd updated to current score. A lower score in the next game leaves high_bcd unchanged.
- DEAD; start_btn edge -> ignored. OVER; start_btn edge -> PLAY with score_bcd=000 and high_bcd kept.
- Same-cycle score_pulse + hit frame_en at score 004 -> score_bcd=005, state=DEAD. Assert rst mid-PLAY -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/bird_collide_judge.sv
// Game state machine, collision detection and BCD score keeping for the bird game.
// Define BIRD_PIPE_INVINCIBLE_EN to ignore pipe collisions (ground/ceiling still end the game).
module bird_collide_judge #(
  parameter int unsigned BIRD_X       = 300,
  parameter int unsigned BIRD_SIZE    = 32,
  parameter int unsigned PIPE_W       = 80,
  parameter int unsigned PIPE_GAP_H   = 220,
  parameter int unsigned GROUND_Y     = 700,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_en,
  input  logic        start_btn,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_gap_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_gap_y,
  input  logic        score_pulse,
  output logic        game_active,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [11:0] score_bcd,
  output logic [11:0] high_bcd
);

  localparam int unsigned CntW = $clog2(DEATH_FRAMES + 1);
  localparam logic [12:0] HalfGap = 13'(PIPE_GAP_H / 2);
  localparam logic [CntW-1:0] LastDeath = CntW'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDead = 2'd2,
    StOver = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] death_q, death_d;
  logic [11:0]     score_q, score_d;
  logic [11:0]     high_q, high_d;
  logic            start_q;
  logic            start_re;
  logic            pipe1_hit, pipe2_hit, ground_hit, ceil_hit, hit;

  // All geometry is evaluated in 13 bits so that x+W and y+gap cannot wrap.
  function automatic logic pipe_hit_f(input logic [11:0] px, input logic [11:0] gy,
                                      input logic [11:0] by);
    logic [12:0] x13, g13, b13, upper, lower;
    logic        overlap, miss;
    x13     = {1'b0, px};
    g13     = {1'b0, gy};
    b13     = {1'b0, by};
    overlap = (x13 < 13'(BIRD_X + BIRD_SIZE)) && ((x13 + 13'(PIPE_W)) > 13'(BIRD_X));
    upper   = (g13 < HalfGap) ? 13'd0 : (g13 - HalfGap);
    lower   = g13 + HalfGap;
    miss    = (b13 < upper) || ((b13 + 13'(BIRD_SIZE)) > lower);
    return overlap & miss;
  endfunction

  // Three-digit BCD increment, saturating at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v == 12'h999) begin
      return v;
    end
    if (d0 < 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 < 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  assign start_re = start_btn & ~start_q;

`ifdef BIRD_PIPE_INVINCIBLE_EN
  assign pipe1_hit = 1'b0;
  assign pipe2_hit = 1'b0;
`else
  assign pipe1_hit = pipe_hit_f(pipe1_x, pipe1_gap_y, bird_y);
  assign pipe2_hit = pipe_hit_f(pipe2_x, pipe2_gap_y, bird_y);
`endif

  assign ground_hit = ({1'b0, bird_y} + 13'(BIRD_SIZE)) >= 13'(GROUND_Y);
  assign ceil_hit   = (bird_y == 12'd0) || bird_y[11];
  assign hit        = pipe1_hit | pipe2_hit | ground_hit | ceil_hit;

  always_comb begin
    state_d = state_q;
    death_d = death_q;
    score_d = score_q;
    high_d  = high_q;
    case (state_q)
      StIdle: begin
        if (start_re) begin
          state_d = StPlay;
          score_d = 12'h000;
        end
      end
      StPlay: begin
        if (score_pulse) begin
          score_d = bcd_inc(score_q);
        end
        if (frame_en && hit) begin
          state_d = StDead;
          death_d = '0;
        end
      end
      StDead: begin
        if (frame_en) begin
          if (death_q == LastDeath) begin
            state_d = StOver;
            // Packed BCD orders the same as the numeric value.
            if (score_q > high_q) begin
              high_d = score_q;
            end
          end else begin
            death_d = death_q + 1'b1;
          end
        end
      end
      StOver: begin
        if (start_re) begin
          state_d = StPlay;
          score_d = 12'h000;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      death_q <= '0;
      score_q <= 12'h000;
      high_q  <= 12'h000;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      death_q <= death_d;
      score_q <= score_d;
      high_q  <= high_d;
      start_q <= start_btn;
    end
  end

  assign game_active = (state_q == StPlay);
  assign game_over   = (state_q == StOver);
  assign state       = state_q;
  assign score_bcd   = score_q;
  assign high_bcd    = high_q;

endmodule

// File: tb/tb_bird_collide_judge.sv
// Directed self-checking bench for bird_collide_judge.
module tb_bird_collide_judge;

  logic        clk;
  logic        rst;
  logic        frame_en;
  logic        start_btn;
  logic [11:0] bird_y;
  logic [11:0] pipe1_x;
  logic [11:0] pipe1_gap_y;
  logic [11:0] pipe2_x;
  logic [11:0] pipe2_gap_y;
  logic        score_pulse;
  logic        game_active;
  logic        game_over;
  logic [1:0]  state;
  logic [11:0] score_bcd;
  logic [11:0] high_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bird_collide_judge dut (
    .clk         (clk),
    .rst         (rst),
    .frame_en    (frame_en),
    .start_btn   (start_btn),
    .bird_y      (bird_y),
    .pipe1_x     (pipe1_x),
    .pipe1_gap_y (pipe1_gap_y),
    .pipe2_x     (pipe2_x),
    .pipe2_gap_y (pipe2_gap_y),
    .score_pulse (score_pulse),
    .game_active (game_active),
    .game_over   (game_over),
    .state       (state),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cycle(1);
    start_btn = 1'b0;
    cycle(1);
  endtask

  task automatic frames(input int n);
    frame_en = 1'b1;
    cycle(n);
    frame_en = 1'b0;
  endtask

  task automatic pulses(input int n);
    score_pulse = 1'b1;
    cycle(n);
    score_pulse = 1'b0;
  endtask

  task automatic safe_bird();
    bird_y  = 12'd370;
    pipe1_x = 12'd1024;
    pipe2_x = 12'd1024;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(2);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", game_active); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_over got %b want 0", game_over); end
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_score got %h want 000", score_bcd); end
    n_checks++; if (high_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_high got %h want 000", high_bcd); end
    rst = 1'b0;
    cycle(1);
  endtask

  task automatic test_start();
    // Pulses in IDLE must be ignored.
    pulses(3);
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL idle_pulse got %h want 000", score_bcd); end
    start_btn = 1'b1;
    cycle(1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state got %0d want 1", state); end
    n_checks++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL start_active got %b want 1", game_active); end
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL start_score got %h want 000", score_bcd); end
    start_btn = 1'b0;
    cycle(1);
  endtask

  task automatic test_pipe_hit();
    pipe1_x     = 12'd250;
    pipe1_gap_y = 12'd384;
    bird_y      = 12'd370;
    frames(1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL pipe_in_gap got %0d want 1", state); end
    // Hit is only sampled on frame_en.
    bird_y = 12'd200;
    cycle(2);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL pipe_no_frame got %0d want 1", state); end
    frames(1);
`ifdef BIRD_PIPE_INVINCIBLE_EN
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL pipe_invincible got %0d want 1", state); end
    bird_y = 12'd680;
    frames(1);
`else
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pipe_hit got %0d want 2", state); end
`endif
    n_checks++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL dead_active got %b want 0", game_active); end
    safe_bird();
    frames(60);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL first_over got %0d want 3", state); end
    press_start();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL replay_state got %0d want 1", state); end
  endtask

  task automatic test_score();
    pulses(9);
    n_checks++; if (score_bcd !== 12'h009) begin n_fail++; $display("FAIL score_9 got %h want 009", score_bcd); end
    pulses(1);
    n_checks++; if (score_bcd !== 12'h010) begin n_fail++; $display("FAIL score_10 got %h want 010", score_bcd); end
    pulses(89);
    n_checks++; if (score_bcd !== 12'h099) begin n_fail++; $display("FAIL score_99 got %h want 099", score_bcd); end
    pulses(1);
    n_checks++; if (score_bcd !== 12'h100) begin n_fail++; $display("FAIL score_100 got %h want 100", score_bcd); end
    pulses(899);
    n_checks++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL score_999 got %h want 999", score_bcd); end
    pulses(1);
    n_checks++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL score_sat got %h want 999", score_bcd); end
  endtask

  task automatic test_ground_death();
    n_checks++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL pre_ground_active got %b want 1", game_active); end
    bird_y = 12'd680;
    frames(1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL ground_hit got %0d want 2", state); end
    safe_bird();
    press_start();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL dead_start got %0d want 2", state); end
    pulses(2);
    n_checks++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL dead_pulse got %h want 999", score_bcd); end
    frames(59);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL dead_59 got %0d want 2", state); end
    n_checks++; if (high_bcd !== 12'h000) begin n_fail++; $display("FAIL dead_high got %h want 000", high_bcd); end
    frames(1);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_state got %0d want 3", state); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag got %b want 1", game_over); end
    n_checks++; if (high_bcd !== 12'h999) begin n_fail++; $display("FAIL over_high got %h want 999", high_bcd); end
  endtask

  task automatic test_back_to_back();
    press_start();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_state got %0d want 1", state); end
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL restart_score got %h want 000", score_bcd); end
    n_checks++; if (high_bcd !== 12'h999) begin n_fail++; $display("FAIL restart_high got %h want 999", high_bcd); end
    pulses(4);
    n_checks++; if (score_bcd !== 12'h004) begin n_fail++; $display("FAIL score_4 got %h want 004", score_bcd); end
    bird_y      = 12'd680;
    score_pulse = 1'b1;
    frame_en    = 1'b1;
    cycle(1);
    score_pulse = 1'b0;
    frame_en    = 1'b0;
    n_checks++; if (score_bcd !== 12'h005) begin n_fail++; $display("FAIL same_cycle_score got %h want 005", score_bcd); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL same_cycle_state got %0d want 2", state); end
    safe_bird();
    frames(60);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL over2_state got %0d want 3", state); end
    n_checks++; if (high_bcd !== 12'h999) begin n_fail++; $display("FAIL over2_high got %h want 999", high_bcd); end
    pulses(1);
    n_checks++; if (score_bcd !== 12'h005) begin n_fail++; $display("FAIL over_pulse got %h want 005", score_bcd); end
  endtask

  task automatic test_async_reset();
    press_start();
    pulses(2);
    bird_y = 12'd4095;
    cycle(1);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ceil_no_frame got %0d want 1", state); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_state got %0d want 0", state); end
    n_checks++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL async_active got %b want 0", game_active); end
    n_checks++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL async_score got %h want 000", score_bcd); end
    n_checks++; if (high_bcd !== 12'h000) begin n_fail++; $display("FAIL async_high got %h want 000", high_bcd); end
    cycle(1);
    rst = 1'b0;
    cycle(1);
    press_start();
    bird_y = 12'd0;
    frames(1);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL ceil_zero got %0d want 2", state); end
  endtask

  initial begin
    rst         = 1'b1;
    frame_en    = 1'b0;
    start_btn   = 1'b0;
    score_pulse = 1'b0;
    pipe1_gap_y = 12'd384;
    pipe2_gap_y = 12'd384;
    safe_bird();
    test_reset();
    test_start();
    test_pipe_hit();
    test_score();
    test_ground_death();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
